// File: rtl/button_conditioner.sv
// Purpose: sync + debounce one active-low button; level, press/release/long strobes (BUTTON_CONDITIONER_AUTO_REPEAT_EN adds repeat presses).
// Latency: press/release strobes 2 + DEBOUNCE_COUNT+1 + 1 clk after the raw edge; long strobe LONG_COUNT clk after press.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module button_conditioner #(
    parameter int COUNT_WIDTH    = 24,
    parameter int DEBOUNCE_COUNT = 120000 - 1,
    parameter int LONG_COUNT     = 12000000 - 1,
    parameter int REPEAT_COUNT   = 2400000 - 1
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DEB_MAX  = COUNT_WIDTH'(DEBOUNCE_COUNT);
    localparam logic [COUNT_WIDTH-1:0] LONG_MAX = COUNT_WIDTH'(LONG_COUNT);
    localparam logic [COUNT_WIDTH-1:0] LONG_M1  = COUNT_WIDTH'(LONG_COUNT - 1);

    state_t                 state, state_nxt;
    logic                   sync1, sync2;
    logic                   s;
    logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [COUNT_WIDTH-1:0] hold, hold_nxt;
    logic                   level_nxt, press_nxt, release_nxt, long_nxt;

    // Sync flops reset to "released" so a button held through reset is debounced normally.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam logic [COUNT_WIDTH-1:0] RPT_MAX = COUNT_WIDTH'(REPEAT_COUNT);
    logic [COUNT_WIDTH-1:0] rpt, rpt_nxt;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) rpt <= '0;
        else          rpt <= rpt_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state         <= RELEASED;
            cnt           <= '0;
            hold          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold          <= hold_nxt;
            level         <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold;
        level_nxt   = level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        rpt_nxt     = rpt;
`endif
        case (state)
            RELEASED: begin
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                rpt_nxt = '0;
`endif
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                rpt_nxt = '0;
`endif
                if (!s) begin
                    state_nxt = RELEASED;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (s) begin
                    // hold saturates at LONG_MAX, so the LONG_M1 match fires once per press
                    if (hold != LONG_MAX) hold_nxt = hold + 1'b1;
                    if (hold == LONG_M1)  long_nxt = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                    if (hold == LONG_MAX) begin
                        if (rpt == RPT_MAX) begin
                            press_nxt = 1'b1;
                            rpt_nxt   = '0;
                        end else begin
                            rpt_nxt = rpt + 1'b1;
                        end
                    end
`endif
                end else begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == DEB_MAX) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
                hold_nxt  = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected strobes are queued with their cycle, a monitor pops on every strobe.
module tb_button_conditioner;

    localparam int DEB  = 3;
    localparam int LONG = 20;
    localparam int REP  = 4;
    localparam int LAT  = 7;

    localparam logic [2:0] K_PRESS   = 3'b100;
    localparam logic [2:0] K_RELEASE = 3'b010;
    localparam logic [2:0] K_LONG    = 3'b001;

    logic clk = 1'b0;
    logic rst_btn = 1'b0;
    logic btn_n = 1'b1;
    logic level, press_pulse, release_pulse, long_pulse;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] kind;
        int         at;
        logic       lvl;
    } exp_t;

    exp_t sb[$];

    button_conditioner #(
        .COUNT_WIDTH   (24),
        .DEBOUNCE_COUNT(DEB),
        .LONG_COUNT    (LONG),
        .REPEAT_COUNT  (REP)
    ) dut (
        .clk          (clk),
        .rst_btn      (rst_btn),
        .btn_n        (btn_n),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] kind, input int at, input logic lvl);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.lvl  = lvl;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard in kind, cycle and level.
    always @(negedge clk) begin
        if (press_pulse || release_pulse || long_pulse) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got p/r/l=%b%b%b at cycle %0d, expected none",
                         press_pulse, release_pulse, long_pulse, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({press_pulse, release_pulse, long_pulse} !== e.kind || cyc != e.at || level !== e.lvl) begin
                    n_fail++;
                    $display("FAIL pulse: got p/r/l=%b%b%b lvl=%b cycle=%0d, expected %b lvl=%b cycle=%0d",
                             press_pulse, release_pulse, long_pulse, level, cyc, e.kind, e.lvl, e.at);
                end
            end
        end
    end

    initial begin
        int d;
        int e0;

        // 1: reset held with a toggling button, then released with button up
        tick(1);
        for (int i = 0; i < 6; i++) begin
            btn_n = ~btn_n;
            tick(1);
            check("reset_outputs", {level, press_pulse, release_pulse, long_pulse}, 4'b0000);
        end
        btn_n = 1'b1;
        tick(1);
        rst_btn = 1'b1;
        tick(10);
        check("post_reset_idle", {level, press_pulse, release_pulse, long_pulse}, 4'b0000);

        // 2: clean press and release
        btn_n = 1'b0;
        push(K_PRESS, cyc + LAT, 1'b1);
        tick(15);
        check("clean_press_level", {3'b000, level}, 4'b0001);
        btn_n = 1'b1;
        push(K_RELEASE, cyc + LAT, 1'b0);
        tick(15);
        check("clean_release_level", {3'b000, level}, 4'b0000);

        // 3: bounce shorter than the debounce window
        btn_n = 1'b0; tick(3);
        btn_n = 1'b1; tick(1);
        btn_n = 1'b0; tick(2);
        btn_n = 1'b1; tick(15);
        check("bounce_level", {3'b000, level}, 4'b0000);

        // 4: long press held 40 cycles
        d = cyc;
        btn_n = 1'b0;
        push(K_PRESS, d + LAT, 1'b1);
        push(K_LONG, d + LAT + LONG, 1'b1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        for (int t = d + LAT + LONG + REP + 1; t <= d + 42; t += REP + 1)
            push(K_PRESS, t, 1'b1);
`endif
        tick(40);
        check("long_hold_level", {3'b000, level}, 4'b0001);
        btn_n = 1'b1;
        push(K_RELEASE, cyc + LAT, 1'b0);
        tick(15);

        // 5: short release glitch after the long strobe
        d = cyc;
        btn_n = 1'b0;
        push(K_PRESS, d + LAT, 1'b1);
        push(K_LONG, d + LAT + LONG, 1'b1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        push(K_PRESS, d + 32, 1'b1);
        push(K_PRESS, d + 40, 1'b1);
`endif
        tick(30);
        btn_n = 1'b1; tick(2);
        btn_n = 1'b0; tick(6);
        check("glitch_level", {3'b000, level}, 4'b0001);
        btn_n = 1'b1;
        push(K_RELEASE, cyc + LAT, 1'b0);
        tick(15);

        // 6: reset during PRESS_WAIT and during PRESSED with the button held
        btn_n = 1'b0;
        tick(4);
        rst_btn = 1'b0;
        #1;
        check("reset_in_press_wait", {level, press_pulse, release_pulse, long_pulse}, 4'b0000);
        tick(3);
        rst_btn = 1'b1;
        e0 = cyc;
        push(K_PRESS, e0 + LAT, 1'b1);
        tick(10);
        check("pressed_before_reset", {3'b000, level}, 4'b0001);
        rst_btn = 1'b0;
        #1;
        check("reset_in_pressed", {level, press_pulse, release_pulse, long_pulse}, 4'b0000);
        tick(2);
        rst_btn = 1'b1;
        e0 = cyc;
        push(K_PRESS, e0 + LAT, 1'b1);
        tick(12);
        btn_n = 1'b1;
        push(K_RELEASE, cyc + LAT, 1'b0);
        tick(15);
        check("final_level", {3'b000, level}, 4'b0000);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: %0d expected strobes never seen, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
